// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC next-select codes, direct-source codes and
// the fetch sequencer state encoding.
package cpu_pkg;

    // PC register next-value select
    localparam logic [1:0] PCM_HOLD   = 2'b00;
    localparam logic [1:0] PCM_DIRECT = 2'b01;
    localparam logic [1:0] PCM_INC    = 2'b10;
    localparam logic [1:0] PCM_ZERO   = 2'b11;

    // Source for a direct PC load
    localparam logic [1:0] DIR_RESULT = 2'b00;
    localparam logic [1:0] DIR_IMM    = 2'b01;
    localparam logic [1:0] DIR_REG    = 2'b10;
    localparam logic [1:0] DIR_ZERO   = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_REDIR = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Up-counter of cycles spent waiting for an instruction-memory ack.
// term is raised while the count sits on TERM_CNT-1, i.e. during the
// TERM_CNT-th consecutive waiting cycle.
module fetch_timeout_cnt #(
    parameter int CNT_W    = 8,
    parameter int TERM_CNT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERM_CNT - 1);

    // Count enabled cycles; clear wins over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Terminal flag on the last permitted waiting cycle
    always_comb begin
        term = (count == TERM_VAL);
    end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: steers the PC register, runs the imem req/ack
// handshake, holds the fetched word for decode, and handles redirects,
// halt/resume and fetch timeouts.
module fetch_seq
    import cpu_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    output logic [1:0]      pc_mux,
    output logic [1:0]      pc_direct_ch,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redir_valid,
    input  logic [1:0]      redir_src,
    output logic            flush,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            fault,
    output logic [PC_W-1:0] fault_pc
);

    fetch_state_t state, state_next;

    logic       load_instr;
    logic       drop_valid;
    logic       capture_fault;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_term;
    logic [7:0] cnt_value;

    fetch_timeout_cnt #(
        .CNT_W    (8),
        .TERM_CNT (ACK_TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_value),
        .term  (cnt_term)
    );

    // State register; reset lands in INIT so imem_req drops immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and PC/memory control decode
    always_comb begin
        state_next    = state;
        pc_mux        = PCM_HOLD;
        pc_direct_ch  = DIR_RESULT;
        imem_req      = 1'b0;
        flush         = 1'b0;
        load_instr    = 1'b0;
        drop_valid    = 1'b0;
        capture_fault = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;

        case (state)
            ST_INIT: begin
                pc_mux     = PCM_ZERO;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redir_valid) begin
                    // A concurrent ack belongs to the squashed path
                    pc_mux       = PCM_DIRECT;
                    pc_direct_ch = redir_src;
                    flush        = 1'b1;
                    state_next   = ST_REDIR;
                end else if (imem_ack) begin
                    load_instr = 1'b1;
                    pc_mux     = PCM_INC;
                    state_next = ST_HOLD;
                end else if (halt_req) begin
                    state_next = ST_HALT;
                end else if (cnt_term) begin
                    capture_fault = 1'b1;
                    state_next    = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    pc_mux       = PCM_DIRECT;
                    pc_direct_ch = redir_src;
                    flush        = 1'b1;
                    drop_valid   = 1'b1;
                    state_next   = ST_REDIR;
                end else if (instr_valid && instr_ready) begin
                    drop_valid = 1'b1;
                    state_next = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_REDIR: begin
                state_next = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (redir_valid) begin
                    // Debug set-PC path: nothing younger to flush
                    pc_mux       = PCM_DIRECT;
                    pc_direct_ch = redir_src;
                end
                if (resume && !halt_req) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        cnt_en  = (state == ST_FETCH);
        cnt_clr = (state_next != ST_FETCH);
    end

    // Instruction holding register and its valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (load_instr) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end else if (drop_valid) begin
            instr_valid <= 1'b0;
        end
    end

    // PC of the fetch that timed out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_pc <= '0;
        end else if (capture_fault) begin
            fault_pc <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a simple PC register model around it.
module tb_fetch_seq;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] pc;
    logic [1:0]      pc_mux;
    logic [1:0]      pc_direct_ch;
    logic            imem_req;
    logic            imem_ack;
    logic [15:0]     imem_rdata;
    logic [15:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            redir_valid;
    logic [1:0]      redir_src;
    logic            flush;
    logic            halt_req;
    logic            resume;
    logic            halted;
    logic            fault;
    logic [PC_W-1:0] fault_pc;

    logic [PC_W-1:0] result_val;
    logic [PC_W-1:0] imm_val;
    logic [PC_W-1:0] reg_val;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_seq #(
        .PC_W        (PC_W),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_mux       (pc_mux),
        .pc_direct_ch (pc_direct_ch),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redir_valid  (redir_valid),
        .redir_src    (redir_src),
        .flush        (flush),
        .halt_req     (halt_req),
        .resume       (resume),
        .halted       (halted),
        .fault        (fault),
        .fault_pc     (fault_pc)
    );

    always #5 clk = ~clk;

    // PC register surrounding the sequencer
    initial pc = 10'h3F0;
    always @(posedge clk) begin
        case (pc_mux)
            2'b01: begin
                case (pc_direct_ch)
                    2'b00:   pc <= result_val;
                    2'b01:   pc <= imm_val;
                    2'b10:   pc <= reg_val;
                    default: pc <= '0;
                endcase
            end
            2'b10:   pc <= pc + 10'd2;
            2'b11:   pc <= '0;
            default: pc <= pc;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs may then be changed, outputs settle by #1 more
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        redir_valid = 1'b0;
        redir_src   = 2'b00;
        halt_req    = 1'b0;
        resume      = 1'b0;
        result_val  = 10'h040;
        imm_val     = 10'h020;
        reg_val     = 10'h080;

        // Reset state
        step(); step();
        check("rst_pc_mux", 32'(pc_mux), 32'h3);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_pc", 32'(fault_pc), 32'h0);

        // Zero-wait fetches of A001 and A002
        reset = 1'b0;
        #1;
        check("init_pc_mux", 32'(pc_mux), 32'h3);
        step();                                  // FETCH, pc=0
        check("f1_pc", 32'(pc), 32'h0);
        imem_ack = 1'b1; imem_rdata = 16'hA001; instr_ready = 1'b1;
        #1;
        check("f1_req", 32'(imem_req), 32'h1);
        check("f1_pc_mux", 32'(pc_mux), 32'h2);
        step();                                  // HOLD
        check("h1_instr", 32'(instr), 32'hA001);
        check("h1_valid", 32'(instr_valid), 32'h1);
        check("h1_pc_mux", 32'(pc_mux), 32'h0);
        check("h1_req", 32'(imem_req), 32'h0);
        step();                                  // FETCH, pc=2
        check("f2_valid", 32'(instr_valid), 32'h0);
        imem_rdata = 16'hA002;
        #1;
        check("f2_pc_mux", 32'(pc_mux), 32'h2);
        step();                                  // HOLD
        check("h2_instr", 32'(instr), 32'hA002);
        check("h2_valid", 32'(instr_valid), 32'h1);
        check("h2_pc", 32'(pc), 32'h4);

        // One more fetch to reach PC=6, then hold without ready
        step();                                  // FETCH, pc=4
        imem_rdata = 16'hA003;
        step();                                  // HOLD, pc=6
        imem_ack = 1'b0; instr_ready = 1'b0;
        check("h3_pc", 32'(pc), 32'h6);
        step();                                  // still HOLD
        check("h3_stay_valid", 32'(instr_valid), 32'h1);

        // Redirect from HOLD
        redir_valid = 1'b1; redir_src = 2'b01;
        #1;
        check("rh_pc_mux", 32'(pc_mux), 32'h1);
        check("rh_dir", 32'(pc_direct_ch), 32'h1);
        check("rh_flush", 32'(flush), 32'h1);
        step();                                  // REDIR
        redir_valid = 1'b0;
        #1;
        check("rh_flush_once", 32'(flush), 32'h0);
        check("rh_valid_drop", 32'(instr_valid), 32'h0);
        check("rh_bubble_req", 32'(imem_req), 32'h0);
        step();                                  // FETCH at imm target
        check("rh_req_back", 32'(imem_req), 32'h1);
        check("rh_pc", 32'(pc), 32'h020);

        // Redirect and ack in the same FETCH cycle
        redir_valid = 1'b1; redir_src = 2'b00;
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        check("ra_pc_mux", 32'(pc_mux), 32'h1);
        check("ra_flush", 32'(flush), 32'h1);
        step();                                  // REDIR
        redir_valid = 1'b0; imem_ack = 1'b0;
        check("ra_valid", 32'(instr_valid), 32'h0);
        check("ra_instr_kept", 32'(instr), 32'hA003);
        step();                                  // FETCH at 0x040
        check("ra_pc", 32'(pc), 32'h040);

        // Halt requested while HOLD handshake completes
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();                                  // HOLD
        imem_ack = 1'b0;
        halt_req = 1'b1; instr_ready = 1'b1;
        step();                                  // HALT
        instr_ready = 1'b0;
        #1;
        check("hl_halted", 32'(halted), 32'h1);
        check("hl_req", 32'(imem_req), 32'h0);
        check("hl_valid", 32'(instr_valid), 32'h0);
        redir_valid = 1'b1; redir_src = 2'b10;
        #1;
        check("hl_set_pc_mux", 32'(pc_mux), 32'h1);
        check("hl_set_dir", 32'(pc_direct_ch), 32'h2);
        check("hl_set_noflush", 32'(flush), 32'h0);
        step();
        redir_valid = 1'b0;
        check("hl_still_halted", 32'(halted), 32'h1);
        check("hl_pc", 32'(pc), 32'h080);
        resume = 1'b1;
        step();                                  // resume ignored
        check("hl_resume_ignored", 32'(halted), 32'h1);
        halt_req = 1'b0;
        step();                                  // FETCH
        resume = 1'b0;
        check("hl_resume_fetch", 32'(imem_req), 32'h1);
        check("hl_resume_halted", 32'(halted), 32'h0);

        // Redirect to 0x010 and let the fetch time out
        result_val = 10'h010;
        redir_valid = 1'b1; redir_src = 2'b00;
        step();                                  // REDIR
        redir_valid = 1'b0;
        step();                                  // FETCH cycle 1
        check("to_pc", 32'(pc), 32'h010);
        check("to_req", 32'(imem_req), 32'h1);
        step(); step();                          // FETCH cycles 2,3
        check("to_not_yet", 32'(fault), 32'h0);
        step();                                  // FETCH cycle 4
        check("to_still_fetch", 32'(imem_req), 32'h1);
        step();                                  // FAULT
        check("to_fault", 32'(fault), 32'h1);
        check("to_fault_pc", 32'(fault_pc), 32'h010);
        check("to_req_low", 32'(imem_req), 32'h0);
        redir_valid = 1'b1; imem_ack = 1'b1; resume = 1'b1;
        step(); step();
        check("to_sticky", 32'(fault), 32'h1);
        check("to_pc_mux", 32'(pc_mux), 32'h0);
        redir_valid = 1'b0; imem_ack = 1'b0; resume = 1'b0;
        reset = 1'b1;
        #1;
        check("to_reset_clears", 32'(fault), 32'h0);
        step();
        reset = 1'b0;
        step();                                  // FETCH

        // Reset asserted in the middle of a FETCH cycle
        check("mr_pre_req", 32'(imem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_req_drop", 32'(imem_req), 32'h0);
        check("mr_valid", 32'(instr_valid), 32'h0);
        check("mr_init_pc_mux", 32'(pc_mux), 32'h3);
        step();
        reset = 1'b0;
        #1;
        check("mr_init_after", 32'(pc_mux), 32'h3);
        step();
        check("mr_fetch_after", 32'(imem_req), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Sequences the program-counter register: drives its next-PC select (pc_mux) and redirect source select (pc_direct_ch).
- Runs the instruction-memory request/acknowledge handshake and holds the fetched 16-bit word for decode under a valid/ready handshake.
- Handles redirects, halt/resume and fetch-timeout faults.
- Sits between the PC register, instruction memory and the decode/execute stages.

Parameters:
- PC_W, 10, PC width in bits; matches the PC register.
- ACK_TIMEOUT, 15, FETCH cycles without imem_ack before entering FAULT (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pc  in  PC_W  current PC from the PC register (fault capture only)
- pc_mux  out  2  PC next select: 00 hold, 01 direct, 10 PC+2, 11 zero
- pc_direct_ch  out  2  direct source: 00 ALU result, 01 instr[9:0], 10 register read, 11 zero
- imem_req  out  1  fetch request at address pc
- imem_ack  in  1  fetch data valid; meaningful only while imem_req=1
- imem_rdata  in  16  fetched instruction word
- instr  out  16  held instruction to decode
- instr_valid  out  1  instr holds a live instruction
- instr_ready  in  1  decode accepts instr
- redir_valid  in  1  one-cycle redirect request from execute
- redir_src  in  2  redirect source, passed to pc_direct_ch
- flush  out  1  one-cycle pulse: discard younger work
- halt_req  in  1  level; stop at next instruction boundary
- resume  in  1  pulse; leave HALT
- halted  out  1  in HALT
- fault  out  1  in FAULT
- fault_pc  out  PC_W  PC of the timed-out fetch

Behaviour:
- States: INIT, FETCH, HOLD, REDIR, HALT, FAULT, held in a one-hot or 3-bit register.
- Reset values: state INIT; instr=0; instr_valid=0; imem_req=0; flush=0; halted=0; fault=0; fault_pc=0; timeout counter 0. pc_mux=11, pc_direct_ch=00 while in INIT.
- Default outputs in every state: pc_mux=00, pc_direct_ch=00, imem_req=0, flush=0.
- INIT: pc_mux=11 (PC loads 0); next state FETCH.
- FETCH:
  - imem_req=1; counter increments each cycle without ack.
  - Priority 1, redir_valid: pc_mux=01, pc_direct_ch=redir_src, flush=1, any ack this cycle discarded, next REDIR.
  - Priority 2, halt_req with no ack: abort the fetch, next HALT.
  - Priority 3, imem_ack: instr<=imem_rdata, instr_valid<=1, pc_mux=10, counter cleared, next HOLD. Ack takes precedence over halt_req in the same cycle.
  - Priority 4, counter==ACK_TIMEOUT-1 with no ack: fault_pc<=pc, next FAULT.
- HOLD:
  - imem_req=0; instr stable.
  - Handshake completes when instr_valid&instr_ready.
  - redir_valid: pc_mux=01, pc_direct_ch=redir_src, flush=1, instr_valid<=0, next REDIR. Any concurrent handshake is honoured; the instruction counts as consumed.
  - Otherwise, on handshake: instr_valid<=0; next HALT if halt_req, else FETCH.
  - Otherwise stay in HOLD.
- REDIR: one bubble cycle with imem_req=0, so the memory sees the aborted request dropped; next HALT if halt_req, else FETCH.
- HALT:
  - halted=1, imem_req=0.
  - redir_valid loads PC (pc_mux=01) and stays in HALT; no flush. This is the debug set-PC path.
  - resume (and no halt_req): next FETCH. resume while halt_req=1 is ignored.
- FAULT: fault=1, pc_mux=00, imem_req=0; left only by reset.
- Latency: redirect-to-fetch of the new PC is 2 cycles (REDIR bubble). Back-to-back fetch with zero-wait memory and instr_ready=1 is one instruction per 2 cycles (FETCH, HOLD).
- PC wrap-around at 2^PC_W is the PC register's modulo behaviour; no special handling.
- Reset mid-fetch drops imem_req asynchronously.

Decomposition:
- Shared package cpu_pkg holds:
  - pc_mux codes: PCM_HOLD=00, PCM_DIRECT=01, PCM_INC=10, PCM_ZERO=11.
  - Direct-source codes: DIR_RESULT=00, DIR_IMM=01, DIR_REG=10, DIR_ZERO=11.
  - The state enum.
- One sub-module, fetch_timeout_cnt: counter with clear, enable and terminal flag.

Test Plan:
- Reset release, imem_ack same cycle as req, instr_ready=1, rdata 16'hA001 then 16'hA002:
  - pc_mux 11, then 00/10 alternating.
  - instr_valid high with A001, then A002.
  - PC reaches 4 after two fetches.
- PC=6, HOLD with instr_ready=0, redir_valid with redir_src=01:
  - pc_mux=01, pc_direct_ch=01, flush=1 for exactly one cycle.
  - instr_valid drops; imem_req low one cycle, then high.
- FETCH with redir_valid and imem_ack in the same cycle:
  - Word discarded, instr_valid stays 0.
  - pc_mux=01, not 10.
- halt_req=1 during HOLD, handshake completes:
  - halted=1, imem_req=0.
  - redir_valid src 10 in HALT gives pc_mux=01 and stays halted.
  - resume gives FETCH next cycle.
- ACK_TIMEOUT=4, imem_ack stuck 0 at PC=0x010:
  - FAULT after 4 FETCH cycles: fault=1, fault_pc=0x010, imem_req=0.
  - Stays there until reset; reset clears fault.
- Assert reset mid-FETCH: imem_req=0 and instr_valid=0 immediately; INIT, then FETCH after release.
